// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute controller driving reg_file_alu control inputs.
// Latency: 3 cycles per instruction (FETCH, DECODE, EXECUTE) while run is high.
// Backpressure: run low holds the sequencer in FETCH; an instruction in flight always completes.
module instr_sequencer #(
    parameter int PC_W = 8,
    parameter int IW   = 16
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            run,
    input  logic [IW-1:0]   imem_data,
    input  logic            Zero,
    output logic [PC_W-1:0] imem_addr,
    output logic [3:0]      RA1,
    output logic [3:0]      RA2,
    output logic [3:0]      WA,
    output logic [7:0]      immediate,
    output logic [1:0]      ALUControl,
    output logic            write_enable,
    output logic            ALUSrc,
    output logic            halted,
    output logic [15:0]     instr_count
);

    localparam logic [1:0] S_FETCH   = 2'd0;
    localparam logic [1:0] S_DECODE  = 2'd1;
    localparam logic [1:0] S_EXECUTE = 2'd2;
    localparam logic [1:0] S_HALT    = 2'd3;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] target;
    logic [IW-1:0]   ir;
    logic            zflag;
    logic [3:0]      op;
    logic            is_rtype;
    logic            is_itype;
    logic            is_alu;
    logic            is_bz;
    logic            is_jmp;
    logic            is_halt;

    assign op       = ir[15:12];
    assign is_rtype = (op >= 4'd1) && (op <= 4'd4);
    assign is_itype = (op >= 4'd5) && (op <= 4'd8);
    assign is_alu   = is_rtype || is_itype;
    assign is_bz    = (op == 4'h9);
    assign is_jmp   = (op == 4'hA);
    assign is_halt  = (op == 4'hF);

    // Branch target is the low byte of IR, fitted to the PC width.
    generate
        if (PC_W > 8) begin : g_tgt_ext
            assign target = {{(PC_W-8){1'b0}}, ir[7:0]};
        end else if (PC_W == 8) begin : g_tgt_eq
            assign target = ir[7:0];
        end else begin : g_tgt_trunc
            assign target = ir[PC_W-1:0];
        end
    endgenerate

    assign imem_addr    = pc;
    assign write_enable = (state == S_EXECUTE) && is_alu;
    assign halted       = (state == S_HALT);

    // Opcodes 1-4 and 5-8 both map to ALU ops via op[1:0]-1 (1,2,3,0 -> 0,1,2,3).
    always_comb begin
        RA1        = 4'h0;
        RA2        = 4'h0;
        WA         = 4'h0;
        immediate  = 8'h00;
        ALUControl = 2'b00;
        ALUSrc     = 1'b0;
        if (is_rtype) begin
            WA         = ir[11:8];
            RA1        = ir[7:4];
            RA2        = ir[3:0];
            ALUControl = op[1:0] - 2'd1;
        end else if (is_itype) begin
            WA         = ir[11:8];
            RA1        = ir[11:8];
            immediate  = ir[7:0];
            ALUControl = op[1:0] - 2'd1;
            ALUSrc     = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_FETCH: begin
                if (run) begin
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                state_nxt = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_jmp || (is_bz && zflag)) begin
                    pc_nxt = target;
                end else begin
                    pc_nxt = pc + PC_W'(1);
                end
                state_nxt = is_halt ? S_HALT : S_FETCH;
            end
            default: begin
                state_nxt = S_HALT;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_FETCH;
            pc          <= '0;
            ir          <= '0;
            zflag       <= 1'b0;
            instr_count <= 16'h0000;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (state == S_DECODE) begin
                ir <= imem_data;
            end
            if (state == S_EXECUTE) begin
                // BZ consumes the flag of the last ALU instruction, not the live Zero.
                if (is_alu) begin
                    zflag <= Zero;
                end
                if (instr_count != 16'hFFFF) begin
                    instr_count <= instr_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: ISA-level reference model feeds a scoreboard checked by a negedge monitor.
module tb_instr_sequencer;

    typedef struct packed {
        logic [3:0] wa;
        logic [3:0] ra1;
        logic [3:0] ra2;
        logic [7:0] imm;
        logic [1:0] alu;
        logic       src;
    } wr_t;

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] cnt;
        logic        halt;
    } ret_t;

    logic        CLK;
    logic        nRST;
    logic        run;
    logic [15:0] imem_data;
    logic        Zero;
    logic [7:0]  imem_addr;
    logic [3:0]  RA1;
    logic [3:0]  RA2;
    logic [3:0]  WA;
    logic [7:0]  immediate;
    logic [1:0]  ALUControl;
    logic        write_enable;
    logic        ALUSrc;
    logic        halted;
    logic [15:0] instr_count;

    logic [15:0] rom [256];
    logic        zero_tab [256];
    wr_t         wq[$];
    ret_t        rq[$];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  last_ret = -1;
    bit  mon_en  = 0;
    bit  tp_chk  = 0;
    logic        prev_we  = 1'b0;
    logic [15:0] prev_cnt = 16'h0;

    instr_sequencer #(.PC_W(8), .IW(16)) dut (
        .CLK(CLK), .nRST(nRST), .run(run), .imem_data(imem_data), .Zero(Zero),
        .imem_addr(imem_addr), .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate),
        .ALUControl(ALUControl), .write_enable(write_enable), .ALUSrc(ALUSrc),
        .halted(halted), .instr_count(instr_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Synchronous ROM; the ALU's Zero is a per-instruction random value keyed by retirement index.
    always @(posedge CLK) imem_data <= rom[imem_addr];
    assign Zero = zero_tab[instr_count[7:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Architectural model: executes the ROM program instruction by instruction.
    task automatic model_run(input int max_steps, output int n_ret);
        int pc, cnt, opi;
        logic [15:0] ins;
        logic zf;
        wr_t w;
        ret_t r;
        pc = 0; cnt = 0; zf = 1'b0; n_ret = 0;
        for (int s = 0; s < max_steps; s++) begin
            ins = rom[pc];
            opi = int'(ins[15:12]);
            if (opi >= 1 && opi <= 8) begin
                w.wa  = ins[11:8];
                w.ra1 = (opi <= 4) ? ins[7:4] : ins[11:8];
                w.ra2 = (opi <= 4) ? ins[3:0] : 4'h0;
                w.imm = (opi <= 4) ? 8'h00 : ins[7:0];
                w.alu = 2'((opi <= 4) ? opi - 1 : opi - 5);
                w.src = (opi >= 5);
                wq.push_back(w);
                zf = zero_tab[cnt % 256];
            end
            if (opi == 10 || (opi == 9 && zf)) pc = int'(ins[7:0]);
            else pc = (pc + 1) % 256;
            if (cnt < 65535) cnt++;
            r.pc = 8'(pc); r.cnt = 16'(cnt); r.halt = (opi == 15);
            rq.push_back(r);
            n_ret++;
            if (opi == 15) break;
        end
    endtask

    always @(negedge CLK) begin
        wr_t w;
        ret_t r;
        cyc++;
        if (!nRST) begin
            last_ret = -1;
        end else if (mon_en) begin
            if (write_enable) begin
                check("we_single_cycle", 32'(prev_we), 32'd0);
                check("wq_nonempty", 32'(wq.size() != 0), 32'd1);
                if (wq.size() != 0) begin
                    w = wq.pop_front();
                    check("WA", 32'(WA), 32'(w.wa));
                    check("RA1", 32'(RA1), 32'(w.ra1));
                    check("RA2", 32'(RA2), 32'(w.ra2));
                    check("immediate", 32'(immediate), 32'(w.imm));
                    check("ALUControl", 32'(ALUControl), 32'(w.alu));
                    check("ALUSrc", 32'(ALUSrc), 32'(w.src));
                end
            end
            if (instr_count != prev_cnt) begin
                check("rq_nonempty", 32'(rq.size() != 0), 32'd1);
                if (rq.size() != 0) begin
                    r = rq.pop_front();
                    check("instr_count", 32'(instr_count), 32'(r.cnt));
                    check("pc", 32'(imem_addr), 32'(r.pc));
                    check("halted", 32'(halted), 32'(r.halt));
                    if (tp_chk && last_ret >= 0) check("cycles_per_instr", 32'(cyc - last_ret), 32'd3);
                end
                last_ret = cyc;
            end
        end
        prev_we  = write_enable;
        prev_cnt = instr_count;
    end

    task automatic do_reset();
        run  = 1'b0;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
    endtask

    task automatic run_until(input logic [15:0] target, input bit rnd);
        bit done = 0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge CLK);
            if (instr_count == target) done = 1;
            else run = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        run = 1'b0;
        check("run_until_reached", 32'(done), 32'd1);
    endtask

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 16'h0000;
            zero_tab[i] = 1'($urandom_range(0, 1));
        end
        wq.delete();
        rq.delete();
    endtask

    initial begin
        int n, edges;
        bit seen;
        nRST = 1'b0;
        run  = 1'b0;
        clear_prog();
        #1;
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_we", 32'(write_enable), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_decode", {RA1, RA2, WA, immediate, ALUControl, ALUSrc}, 32'd0);

        // Directed program: ALU ops, taken/not-taken BZ, JMP to 0xFF and wrap to 0.
        clear_prog();
        rom[8'h00] = 16'h5305; rom[8'h01] = 16'h2312; rom[8'h02] = 16'h1456;
        rom[8'h03] = 16'h9040; rom[8'h40] = 16'h3111; rom[8'h41] = 16'h9020;
        rom[8'h42] = 16'hA010; rom[8'h10] = 16'hA0FF; rom[8'hFF] = 16'h0000;
        zero_tab[2] = 1'b1; zero_tab[3] = 1'b0; zero_tab[4] = 1'b0; zero_tab[5] = 1'b1;
        model_run(9, n);
        do_reset();
        mon_en = 1; tp_chk = 1;
        run = 1'b1;
        edges = 0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge CLK);
            edges++;
            if (write_enable) seen = 1;
        end
        check("first_exec_latency", 32'(edges), 32'd2);
        run_until(16'(n), 1'b0);
        repeat (5) @(negedge CLK);
        check("stall_pc_wrapped", 32'(imem_addr), 32'd0);
        check("directed_wq_drained", 32'(wq.size()), 32'd0);
        check("directed_rq_drained", 32'(rq.size()), 32'd0);
        mon_en = 0; tp_chk = 0;

        // HALT: terminal state, PC frozen regardless of run.
        clear_prog();
        rom[0] = 16'h1123; rom[1] = 16'hF000;
        model_run(10, n);
        do_reset();
        mon_en = 1;
        run_until(16'(n), 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            run = 1'($urandom_range(0, 1));
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_we", 32'(write_enable), 32'd0);
            check("halt_pc", 32'(imem_addr), 32'd2);
        end
        check("halt_rq_drained", 32'(rq.size()), 32'd0);
        mon_en = 0;

        // Asynchronous reset during EXECUTE of the second instruction.
        clear_prog();
        rom[0] = 16'h5305; rom[1] = 16'h1456;
        do_reset();
        run = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge CLK);
            if (write_enable && instr_count == 16'd1) seen = 1;
        end
        check("rst_mid_reached", 32'(seen), 32'd1);
        nRST = 1'b0;
        #1;
        check("rst_mid_we", 32'(write_enable), 32'd0);
        check("rst_mid_count", 32'(instr_count), 32'd0);
        check("rst_mid_pc", 32'(imem_addr), 32'd0);
        check("rst_mid_RA1", 32'(RA1), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;
        run  = 1'b1;
        edges = 0; seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge CLK);
            edges++;
            if (write_enable) seen = 1;
        end
        check("post_rst_latency", 32'(edges), 32'd2);
        check("post_rst_WA", 32'(WA), 32'd3);
        check("post_rst_count", 32'(instr_count), 32'd0);
        run = 1'b0;

        // Random programs with random run gating.
        for (int it = 0; it < 4; it++) begin
            mon_en = 0;
            clear_prog();
            for (int i = 0; i < 256; i++) rom[i] = 16'($urandom_range(0, 16'hFFFF));
            model_run(40, n);
            do_reset();
            mon_en = 1;
            run_until(16'(n), 1'b1);
            repeat (4) @(negedge CLK);
            check("rand_wq_drained", 32'(wq.size()), 32'd0);
            check("rand_rq_drained", 32'(rq.size()), 32'd0);
        end
        mon_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
